// File: rtl/quiz_remote_encoder.sv
// ============================================================================
// quiz_remote_encoder : debounces two 4-button handsets, arbitrates presses and
//                       sends fixed-length active-low one-hot frames on the bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module quiz_remote_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_p1,
  input  logic [3:0] btn_p2,
  output logic [7:0] rm_out_bcd,
  output logic       tx_valid,
  output logic       busy
);

  localparam logic [0:0] DB_REL     = 1'b0;
  localparam logic [0:0] DB_PRESSED = 1'b1;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_SEND = 2'd1;
  localparam logic [1:0] TX_GAP  = 2'd2;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0][3:0] btn_raw;
  logic [1:0][3:0] choice;
  logic [1:0]      pending_set;

  // index 0 is player 1, index 1 is player 2
  assign btn_raw = {btn_p2, btn_p1};

  for (genvar p = 0; p < 2; p++) begin : g_player
    logic [3:0]       sync_a;
    logic [3:0]       sync_b;
    logic [3:0]       prev;
    logic [3:0]       latched;
    logic [0:0]       db_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] run_len;
    logic             one_hot;
    logic             press_done;

    assign one_hot    = (sync_b != 4'd0) && ((sync_b & (sync_b - 4'd1)) == 4'd0);
    assign cnt_inc    = cnt + CNT_ONE;
    // a fresh one-hot value starts a new run at length 1
    assign run_len    = (sync_b == prev) ? cnt_inc : CNT_ONE;
    assign press_done = (db_state == DB_REL) && one_hot && (run_len == DB_LAST);

    assign pending_set[p] = press_done;
    assign choice[p]      = latched;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_a   <= 4'd0;
        sync_b   <= 4'd0;
        prev     <= 4'd0;
        latched  <= 4'd0;
        db_state <= DB_REL;
        cnt      <= '0;
      end else begin
        sync_a <= btn_raw[p];
        sync_b <= sync_a;
        prev   <= sync_b;
        if (db_state == DB_REL) begin
          if (press_done) begin
            latched  <= sync_b;
            db_state <= DB_PRESSED;
            cnt      <= '0;
          end else if (one_hot) begin
            cnt <= run_len;
          end else begin
            cnt <= '0;
          end
        end else begin
          if (sync_b != 4'd0) begin
            cnt <= '0;
          end else if (cnt_inc == DB_LAST) begin
            db_state <= DB_REL;
            cnt      <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
      end
    end
  end

  logic [1:0]       tx_state;
  logic [1:0]       pending;
  logic             prio;
  logic [CNT_W-1:0] pulse_cnt;
  logic [1:0]       grant;
  logic [7:0]       code;

  // Arbitration also runs on the GAP cycle so back-to-back frames are
  // separated by exactly one idle bus cycle.
  always_comb begin
    grant = 2'b00;
    if (tx_state != TX_SEND) begin
      if (pending == 2'b11) begin
        grant = prio ? 2'b10 : 2'b01;
      end else begin
        grant = pending;
      end
    end
  end

  always_comb begin
    code = 8'hFF;
    if (grant[0]) begin
      code[7:4] = ~{choice[0][0], choice[0][1], choice[0][2], choice[0][3]};
    end else if (grant[1]) begin
      code[3:0] = ~{choice[1][0], choice[1][1], choice[1][2], choice[1][3]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      pending    <= 2'b00;
      prio       <= 1'b0;
      pulse_cnt  <= '0;
      rm_out_bcd <= 8'hFF;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | pending_set;
      if ((tx_state != TX_SEND) && (pending == 2'b11)) begin
        prio <= ~prio;
      end
      case (tx_state)
        TX_SEND: begin
          if (pulse_cnt == PULSE_LAST) begin
            tx_state   <= TX_GAP;
            rm_out_bcd <= 8'hFF;
            tx_valid   <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt + CNT_ONE;
          end
        end
        default: begin
          if (grant != 2'b00) begin
            tx_state   <= TX_SEND;
            rm_out_bcd <= code;
            tx_valid   <= 1'b1;
            busy       <= 1'b1;
            pulse_cnt  <= '0;
          end else begin
            tx_state   <= TX_IDLE;
            rm_out_bcd <= 8'hFF;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quiz_remote_encoder.sv
// ============================================================================
// tb_quiz_remote_encoder : directed self-checking bench, DEBOUNCE_CYCLES=4,
//                          PULSE_CYCLES=4
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_quiz_remote_encoder;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [3:0] btn_p1 = 4'd0;
  logic [3:0] btn_p2 = 4'd0;
  logic [7:0] rm_out_bcd;
  logic       tx_valid;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  quiz_remote_encoder #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (4),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_p1    (btn_p1),
    .btn_p2    (btn_p2),
    .rm_out_bcd(rm_out_bcd),
    .tx_valid  (tx_valid),
    .busy      (busy)
  );

  task automatic release_all();
    btn_p1 = 4'd0;
    btn_p2 = 4'd0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rm_out_bcd !== 8'hFF || tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: bus=%h tx_valid=%b busy=%b, want ff/0/0", rm_out_bcd, tx_valid, busy);
    end
    rst_n  = 1'b1;
    btn_p1 = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp = (k >= 7) ? 8'hBF : 8'hFF;
      n_cmp++;
      if (rm_out_bcd !== exp) begin
        n_err++;
        $display("FAIL reset_pre_send k=%0d: bus=%h want %h", k, rm_out_bcd, exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rm_out_bcd !== 8'hFF || tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: bus=%h tx_valid=%b busy=%b, want ff/0/0", rm_out_bcd, tx_valid, busy);
    end
    btn_p1 = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rm_out_bcd !== 8'hFF || tx_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle k=%0d: bus=%h tx_valid=%b want ff/0", k, rm_out_bcd, tx_valid);
      end
    end
  endtask

  task automatic test_single_press();
    logic [7:0] exp_bus;
    logic       exp_v;
    logic       exp_b;
    logic       last_v;
    int         frames;
    frames = 0;
    last_v = 1'b0;
    btn_p1 = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_v   = (k >= 7 && k <= 10);
      exp_b   = (k >= 7 && k <= 11);
      exp_bus = exp_v ? 8'h7F : 8'hFF;
      if (tx_valid === 1'b1 && last_v === 1'b0) frames++;
      last_v = tx_valid;
      n_cmp++;
      if (rm_out_bcd !== exp_bus || tx_valid !== exp_v || busy !== exp_b) begin
        n_err++;
        $display("FAIL single_press k=%0d: bus=%h v=%b busy=%b want %h/%b/%b",
                 k, rm_out_bcd, tx_valid, busy, exp_bus, exp_v, exp_b);
      end
    end
    n_cmp++;
    if (frames != 1) begin
      n_err++;
      $display("FAIL single_frame_count: got %0d frames want 1", frames);
    end
    release_all();
  endtask

  task automatic test_bounce();
    logic [7:0] exp;
    btn_p2 = 4'b1000;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      exp = (k >= 15 && k <= 18) ? 8'hFE : 8'hFF;
      n_cmp++;
      if (rm_out_bcd !== exp) begin
        n_err++;
        $display("FAIL bounce k=%0d: bus=%h want %h", k, rm_out_bcd, exp);
      end
      if (k < 10) btn_p2 = (((k / 2) % 2) == 0) ? 4'b1000 : 4'b0000;
      else        btn_p2 = 4'b1000;
    end
    release_all();
  endtask

  task automatic test_invalid_chord();
    btn_p1 = 4'b0011;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rm_out_bcd !== 8'hFF || tx_valid !== 1'b0) begin
        n_err++;
        $display("FAIL invalid_chord k=%0d: bus=%h v=%b want ff/0", k, rm_out_bcd, tx_valid);
      end
    end
    release_all();
  endtask

  task automatic test_simultaneous(input bit p2_first);
    logic [7:0] first;
    logic [7:0] second;
    logic [7:0] exp;
    first  = p2_first ? 8'hFB : 8'hDF;
    second = p2_first ? 8'hDF : 8'hFB;
    btn_p1 = 4'b0100;
    btn_p2 = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k >= 7 && k <= 10)       exp = first;
      else if (k >= 12 && k <= 15) exp = second;
      else                         exp = 8'hFF;
      n_cmp++;
      if (rm_out_bcd !== exp) begin
        n_err++;
        $display("FAIL simultaneous p2_first=%0d k=%0d: bus=%h want %h", p2_first, k, rm_out_bcd, exp);
      end
    end
    release_all();
  endtask

  task automatic test_repress();
    logic [7:0] exp;
    btn_p1 = 4'b0001;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k >= 7 && k <= 10)       exp = 8'h7F;
      else if (k >= 27 && k <= 30) exp = 8'hEF;
      else                         exp = 8'hFF;
      n_cmp++;
      if (rm_out_bcd !== exp) begin
        n_err++;
        $display("FAIL repress k=%0d: bus=%h want %h", k, rm_out_bcd, exp);
      end
      // long release, press choice4, short release, same button again
      if (k < 12)                  btn_p1 = 4'b0001;
      else if (k < 20)             btn_p1 = 4'b0000;
      else if (k < 35)             btn_p1 = 4'b1000;
      else if (k < 37)             btn_p1 = 4'b0000;
      else                         btn_p1 = 4'b1000;
    end
    release_all();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_invalid_chord();
    test_simultaneous(1'b0);
    test_simultaneous(1'b1);
    test_repress();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
